// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the core's load/store port.
// Accepts one request at a time over req_valid/req_ready. After LATENCY cycles it
// services the request against an internal word RAM and returns the result over
// rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   req_valid/ready  request handshake; req_ready is registered, high only in idle
//   req_we           1 = store, 0 = load
//   req_addr         byte address; must be word aligned and inside storage
//   req_wdata/be     store data and per-byte enables
//   rsp_valid/ready  response handshake; response held stable until accepted
//   rsp_rdata        load data (0 for stores and errors)
//   rsp_err          misaligned or out-of-range request
module riscv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // 33 bits so that a 4 GiB storage would still compare correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_be;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          op_we;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic          op_err;
    logic [AW-1:0] op_idx;
    logic          do_write;
    logic [31:0]   rd_word;

    always_comb begin
        accept     = req_valid && req_ready && (state == StIdle);
        enter_resp = ((state == StIdle) && accept && (LATENCY == 1)) ||
                     ((state == StWait) && (cnt == '0));
        // With LATENCY==1 the commit happens on the accept edge, so the operation
        // must come straight from the request inputs rather than the capture regs.
        if (state == StIdle) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_be    = req_be;
        end else begin
            op_we    = cap_we;
            op_addr  = cap_addr;
            op_wdata = cap_wdata;
            op_be    = cap_be;
        end
        op_err   = (op_addr[1:0] != 2'b00) || ({1'b0, op_addr} >= ADDR_LIMIT);
        op_idx   = op_addr[AW+1:2];
        do_write = enter_resp && op_we && !op_err;
        rd_word  = mem[op_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state <= StResp;
                        end else begin
                            state <= StWait;
                            cnt   <= CW'(LATENCY - 2);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt == '0) begin
                        state <= StResp;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase

            // Response is registered on the same edge that commits the memory action.
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= op_err;
                rsp_rdata <= (op_we || op_err) ? 32'h0 : rd_word;
            end
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 4) share clock and reset.
// Requests push model-predicted responses into a per-instance queue; a monitor
// compares every presented response against the queue head.
module tb_riscv_dmem_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_be    [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t      exp_q   [NDUT][$];
    bit [31:0] ref_mem [NDUT][DEPTH];
    bit        seen    [NDUT];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Reference behaviour: word-addressed array, byte-merged stores.
    task automatic predict(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        longint a;
        int     w;
        a       = longint'(addr);
        e.err   = ((a % 4) != 0) || (a >= 4 * DEPTH);
        e.rdata = 32'h0;
        e.acc   = 0;
        if (!e.err) begin
            w = int'(a / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[d][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = ref_mem[d][w];
            end
        end
    endtask

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input bit commit = 1'b1);
        exp_t e;
        int   t;
        t            = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(negedge clk);
        while (!req_ready[d] && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!req_ready[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready got 0 expected 1", d);
            req_valid[d] = 1'b0;
            return;
        end
        if (commit) begin
            predict(d, we, addr, wdata, be, e);
            e.acc = cyc;
            exp_q[d].push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (exp_q[d].size() != 0 && t < 300) begin
            t++;
            @(negedge clk);
        end
        n_tests++;
        if (exp_q[d].size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout dut%0d: pending got %0d expected 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (rsp_valid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp dut%0d: rsp_valid got 1 expected 0", d);
                    end else begin
                        e = exp_q[d][0];
                        if (!seen[d]) check("latency", d, 32'(cyc - e.acc), 32'(lat_of(d)));
                        check("rsp_rdata", d, rsp_rdata[d], e.rdata);
                        check("rsp_err", d, 32'(rsp_err[d]), 32'(e.err));
                        if (rsp_ready[d]) void'(exp_q[d].pop_front());
                    end
                end
                seen[d] = rsp_valid[d];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          w;
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
            seen[d]      = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        check("reset_req_ready", 0, 32'(req_ready[0]), 0);
        check("reset_rsp_valid", 0, 32'(rsp_valid[0]), 0);
        check("reset_rsp_rdata", 0, rsp_rdata[0], 0);
        check("reset_rsp_err", 0, 32'(rsp_err[0]), 0);
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", 0, 32'(req_ready[0]), 1);

        // Fill a small region so every later load reads defined data.
        for (int i = 0; i < 16; i++) issue(0, 1'b1, 32'(i * 4), $urandom, 4'hF);
        issue(0, 1'b1, 32'hFFC, $urandom, 4'hF);

        // Full-word store then load.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drain(0);

        // Partial and empty byte enables.
        issue(0, 1'b1, 32'h10, 32'h0000BBAA, 4'b0011);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0000);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);

        // Misaligned, out-of-range and last-word boundary.
        issue(0, 1'b0, 32'h11, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        issue(0, 1'b0, 32'h0, 32'h0, 4'hF);
        issue(0, 1'b0, 32'hFFC, 32'h0, 4'hF);
        issue(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        drain(0);

        // Backpressure with a stray request that must be ignored.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        w = 0;
        while (!rsp_valid[0] && w < 20) begin
            w++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req_valid[0] = (i == 2);
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'h10;
            req_wdata[0] = 32'h0;
            req_be[0]    = 4'hF;
            @(negedge clk);
            check("bp_req_ready", 0, 32'(req_ready[0]), 0);
            check("bp_rsp_valid", 0, 32'(rsp_valid[0]), 1);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_rsp_valid", 0, 32'(rsp_valid[0]), 0);
        check("post_hs_req_ready", 0, 32'(req_ready[0]), 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        drain(0);

        // Randomised traffic including error cases.
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 7))
                0:       a = a + 32'($urandom_range(1, 3));
                1:       a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
                default: ;
            endcase
            issue(0, 1'($urandom), a, $urandom, 4'($urandom));
        end
        drain(0);

        // Back-to-back store/load pairs on the LATENCY=1 and LATENCY=4 builds.
        for (int d = 1; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) begin
                a = 32'($urandom_range(0, 7) * 4);
                issue(d, 1'b1, a, $urandom, 4'hF);
                issue(d, 1'b0, a, 32'h0, 4'hF);
            end
            drain(d);
        end

        // Reset while a store is in WAIT: the store must not land.
        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        drain(0);
        issue(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midop_req_ready", 0, 32'(req_ready[0]), 0);
        check("midop_rsp_valid", 0, 32'(rsp_valid[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
